// File: rtl/serial_adder_pkg.sv
// Shared types and limits for the bit-serial adder: FSM state encoding,
// legal WIDTH range and the bit-counter sizing rule.
package serial_adder_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  localparam int WIDTH_MIN = 1;
  localparam int WIDTH_MAX = 32;

  // Counter must reach WIDTH-1 without wrapping; a 1-bit adder still needs one bit.
  function automatic int cnt_width(input int w);
    return (w <= 1) ? 1 : $clog2(w);
  endfunction

endpackage

// File: rtl/FULL_ADDER.sv
// Single-bit full adder cell: combinational, no state, no flow control.
module FULL_ADDER (
  output logic Sum,
  output logic Carry_out,
  input  logic A,
  input  logic B,
  input  logic Carry_in
);

  assign Sum       = A ^ B ^ Carry_in;
  assign Carry_out = (A & B) | (Carry_in & (A ^ B));

endmodule

// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder, LSB first: result and Done one cycle after the last of WIDTH shift cycles.
// Start is only honoured in IDLE/DONE; requests during SHIFT are dropped, not queued.
module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic             Start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Carry_in,
  output logic             Busy,
  output logic             Done,
  output logic [WIDTH-1:0] Sum,
  output logic             Carry_out
);

  import serial_adder_pkg::*;

  localparam int CW = cnt_width(WIDTH);

  if (WIDTH < WIDTH_MIN || WIDTH > WIDTH_MAX) begin : g_bad_width
    $error("serial_adder: WIDTH out of range");
  end

  state_t           state, state_nxt;
  logic [WIDTH-1:0] a_sh, b_sh, s_sh, s_nxt, sum_q;
  logic             c_ff, cout_q;
  logic [CW-1:0]    cnt;
  logic             fa_sum, fa_cout;
  logic             last_bit, load;

  FULL_ADDER u_fa (
    .Sum       (fa_sum),
    .Carry_out (fa_cout),
    .A         (a_sh[0]),
    .B         (b_sh[0]),
    .Carry_in  (c_ff)
  );

  // New sum bit enters at the MSB so that after WIDTH shifts bit 0 lands at the LSB.
  if (WIDTH == 1) begin : g_s_w1
    assign s_nxt = fa_sum;
  end else begin : g_s_wn
    assign s_nxt = {fa_sum, s_sh[WIDTH-1:1]};
  end

  assign last_bit = (cnt == CW'(WIDTH - 1));

  always_ff @(posedge Clock) begin
    if (Reset) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    Busy      = 1'b0;
    Done      = 1'b0;
    case (state)
      ST_IDLE: begin
        if (Start) begin
          load      = 1'b1;
          state_nxt = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        Busy = 1'b1;
        if (last_bit) state_nxt = ST_DONE;
      end
      ST_DONE: begin
        Done = 1'b1;
        if (Start) begin
          load      = 1'b1;
          state_nxt = ST_SHIFT;
        end else begin
          state_nxt = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      a_sh   <= '0;
      b_sh   <= '0;
      s_sh   <= '0;
      c_ff   <= 1'b0;
      cnt    <= '0;
      sum_q  <= '0;
      cout_q <= 1'b0;
    end else if (load) begin
      a_sh <= A;
      b_sh <= B;
      s_sh <= '0;
      c_ff <= Carry_in;
      cnt  <= '0;
    end else if (state == ST_SHIFT) begin
      a_sh <= a_sh >> 1;
      b_sh <= b_sh >> 1;
      s_sh <= s_nxt;
      c_ff <= fa_cout;
      cnt  <= cnt + CW'(1);
      // Outputs only ever see the complete result.
      if (last_bit) begin
        sum_q  <= s_nxt;
        cout_q <= fa_cout;
      end
    end
  end

  assign Sum       = sum_q;
  assign Carry_out = cout_q;

endmodule
